// File: rtl/sap3_ext_mem_bridge_if.sv
// Core-side strobes and external pad bus of the SAP-3 memory bridge.
// The bridge uses the slave view; the core/pad side uses the master view.
interface sap3_ext_mem_bridge_if;
  logic [15:0] core_bus;
  logic        core_mar_we;
  logic        core_ram_we;
  logic        core_rd_req;
  logic        core_busy;
  logic [7:0]  core_rd_data;
  logic        core_rd_valid;
  logic [7:0]  pad_in;
  logic [7:0]  pad_out;
  logic [7:0]  pad_oe;
  logic        pad_ale_hi;
  logic        pad_ale_lo;
  logic        pad_we;
  logic        pad_re;

  modport slave (
    input  core_bus, core_mar_we, core_ram_we, core_rd_req, pad_in,
    output core_busy, core_rd_data, core_rd_valid,
    output pad_out, pad_oe, pad_ale_hi, pad_ale_lo, pad_we, pad_re
  );

  modport master (
    output core_bus, core_mar_we, core_ram_we, core_rd_req, pad_in,
    input  core_busy, core_rd_data, core_rd_valid,
    input  pad_out, pad_oe, pad_ale_hi, pad_ale_lo, pad_we, pad_re
  );
endinterface

// File: rtl/sap3_ext_mem_bridge.sv
// SAP-3 external memory bridge: sequences core accesses onto a byte-wide
// multiplexed pad bus (address-high, address-low, then write or read phase).
// Address phases are skipped while the external latch still holds the
// current address. Every output is a flop driven from the next-state values.
module sap3_ext_mem_bridge #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sap3_ext_mem_bridge_if.slave        bus
);

  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR,
    S_RD
  } state_t;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        dirty_q, dirty_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  pad_out_q, pad_out_d;
  logic [7:0]  pad_oe_q, pad_oe_d;
  logic        ale_hi_q, ale_hi_d;
  logic        ale_lo_q, ale_lo_d;
  logic        we_q, we_d;
  logic        re_q, re_d;

  // Next-state sequencing plus pad/core outputs decoded from the next state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dirty_d    = dirty_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.core_mar_we) begin
          addr_d  = bus.core_bus;
          dirty_d = 1'b1;
        end
        // A write takes priority; a simultaneous read request is dropped.
        if (bus.core_ram_we) begin
          wdata_d = bus.core_bus[7:0];
          op_d    = OP_WR;
        end else if (bus.core_rd_req) begin
          op_d    = OP_RD;
        end
        if (bus.core_ram_we || bus.core_rd_req) begin
          if (dirty_q || bus.core_mar_we) begin
            state_d = S_ADDR_HI;
          end else if (bus.core_ram_we) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_WAIT_C;
          end
        end
      end
      S_ADDR_HI: state_d = S_ADDR_LO;
      S_ADDR_LO: begin
        dirty_d = 1'b0;
        if (op_q == OP_WR) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
          cnt_d   = RD_WAIT_C;
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rd_data_d  = bus.pad_in;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decode the pad view of the state being entered so outputs stay Moore
    pad_out_d = 8'h00;
    pad_oe_d  = 8'h00;
    ale_hi_d  = 1'b0;
    ale_lo_d  = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_d)
      S_ADDR_HI: begin
        pad_out_d = addr_d[15:8];
        pad_oe_d  = 8'hFF;
        ale_hi_d  = 1'b1;
      end
      S_ADDR_LO: begin
        pad_out_d = addr_d[7:0];
        pad_oe_d  = 8'hFF;
        ale_lo_d  = 1'b1;
      end
      S_WR: begin
        pad_out_d = wdata_d;
        pad_oe_d  = 8'hFF;
        we_d      = 1'b1;
      end
      S_RD: re_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WR;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      dirty_q    <= 1'b1;
      cnt_q      <= 4'd0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      pad_out_q  <= 8'h00;
      pad_oe_q   <= 8'h00;
      ale_hi_q   <= 1'b0;
      ale_lo_q   <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dirty_q    <= dirty_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      ale_hi_q   <= ale_hi_d;
      ale_lo_q   <= ale_lo_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  assign bus.core_busy     = busy_q;
  assign bus.core_rd_data  = rd_data_q;
  assign bus.core_rd_valid = rd_valid_q;
  assign bus.pad_out       = pad_out_q;
  assign bus.pad_oe        = pad_oe_q;
  assign bus.pad_ale_hi    = ale_hi_q;
  assign bus.pad_ale_lo    = ale_lo_q;
  assign bus.pad_we        = we_q;
  assign bus.pad_re        = re_q;

endmodule

// File: tb/tb_sap3_ext_mem_bridge.sv
// Scoreboard bench for sap3_ext_mem_bridge: the driver models each accepted
// access as a list of expected bus beats; a monitor compares DUT activity.
module tb_sap3_ext_mem_bridge;
  localparam int unsigned RD_WAIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sap3_ext_mem_bridge_if bus_if ();

  sap3_ext_mem_bridge #(.RD_WAIT(RD_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // beat = {pad_out, pad_oe, ale_hi, ale_lo, we, re, busy}
  logic [20:0] exp_q[$];
  logic [7:0]  rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (driver side)
  logic [15:0] m_addr  = 16'h0000;
  logic        m_dirty = 1'b1;
  int          remaining = 0;
  logic [15:0] last_bus = 16'h0000;

  function automatic logic [20:0] beat(input logic [7:0] po, input logic [7:0] oe,
                                       input logic hi, input logic lo,
                                       input logic we, input logic re);
    return {po, oe, hi, lo, we, re, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One core cycle: drive strobes at the negedge and update the model
  task automatic cycle(input logic mar, input logic ram, input logic rd,
                       input logic [15:0] bv, input logic [7:0] pin);
    bit idle;
    int n;
    @(negedge clk);
    idle = (remaining == 0);
    if (!idle) remaining--;
    bus_if.core_mar_we = mar;
    bus_if.core_ram_we = ram;
    bus_if.core_rd_req = rd;
    bus_if.core_bus    = bv;
    if (idle) begin
      if (mar) begin
        m_addr  = bv;
        m_dirty = 1'b1;
      end
      if (ram || rd) begin
        n = 0;
        if (m_dirty) begin
          exp_q.push_back(beat(m_addr[15:8], 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
          exp_q.push_back(beat(m_addr[7:0],  8'hFF, 1'b0, 1'b1, 1'b0, 1'b0));
          m_dirty = 1'b0;
          n = 2;
        end
        if (ram) begin
          exp_q.push_back(beat(bv[7:0], 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
          n += 1;
          $display("txn WR addr=%h data=%h beats=%0d", m_addr, bv[7:0], n);
        end else begin
          bus_if.pad_in = pin;
          for (int i = 0; i <= int'(RD_WAIT); i++)
            exp_q.push_back(beat(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
          n += int'(RD_WAIT) + 1;
          rd_q.push_back(pin);
          $display("txn RD addr=%h pad_in=%h beats=%0d", m_addr, pin, n);
        end
        remaining = n;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Hold reset for n cycles with random strobes, then release
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus_if.core_mar_we = 1'($urandom);
      bus_if.core_ram_we = 1'($urandom);
      bus_if.core_rd_req = 1'($urandom);
      bus_if.core_bus    = 16'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.core_mar_we = 1'b0;
    bus_if.core_ram_we = 1'b0;
    bus_if.core_rd_req = 1'b0;
    m_addr    = 16'h0000;
    m_dirty   = 1'b1;
    remaining = 0;
    $display("txn RESET cycles=%0d", n);
  endtask

  // Monitor: reset state after a reset edge, else pop beats on bus activity
  logic        rst_at_edge = 1'b0;
  logic [7:0]  last_rd = 8'h00;
  always @(posedge clk) rst_at_edge = ~rst_n;

  always @(negedge clk) begin
    logic active;
    logic [20:0] got, exp;
    logic [7:0] d;
    if (rst_at_edge) begin
      chk("reset_state",
          {32'h0, bus_if.pad_out, bus_if.pad_oe, bus_if.pad_ale_hi, bus_if.pad_ale_lo,
           bus_if.pad_we, bus_if.pad_re, bus_if.core_busy, bus_if.core_rd_data,
           bus_if.core_rd_valid}, 64'h0);
      exp_q.delete();
      rd_q.delete();
      last_rd = 8'h00;
    end else begin
      got = {bus_if.pad_out, bus_if.pad_oe, bus_if.pad_ale_hi, bus_if.pad_ale_lo,
             bus_if.pad_we, bus_if.pad_re, bus_if.core_busy};
      active = bus_if.core_busy | bus_if.pad_ale_hi | bus_if.pad_ale_lo |
               bus_if.pad_we | bus_if.pad_re | (bus_if.pad_oe != 8'h00);
      if (active) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(got), 64'h0);
        else begin
          exp = exp_q.pop_front();
          chk("bus_beat", 64'(got), 64'(exp));
        end
      end else begin
        chk("idle_pad_out", 64'(bus_if.pad_out), 64'h0);
      end
      if (bus_if.core_rd_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rd_valid", 64'(bus_if.core_rd_data), 64'h100);
        else begin
          d = rd_q.pop_front();
          last_rd = d;
        end
      end
      chk("rd_data_hold", 64'(bus_if.core_rd_data), 64'(last_rd));
    end
  end

  initial begin
    bus_if.core_bus    = 16'h0000;
    bus_if.core_mar_we = 1'b0;
    bus_if.core_ram_we = 1'b0;
    bus_if.core_rd_req = 1'b0;
    bus_if.pad_in      = 8'h00;

    do_reset(2);

    // Dirty write, then clean write
    cycle(1'b1, 1'b0, 1'b0, 16'h12AB, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 16'h0055, 8'h00);
    idle_cycles(4);
    cycle(1'b0, 1'b1, 1'b0, 16'h0077, 8'h00);
    idle_cycles(2);

    // Clean read returning C3
    cycle(1'b0, 1'b0, 1'b1, 16'h0000, 8'hC3);
    idle_cycles(6);

    // mar_we during a busy write is ignored; next access stays clean
    cycle(1'b1, 1'b1, 1'b0, 16'h4411, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 16'hBEEF, 8'h00);
    idle_cycles(3);
    cycle(1'b0, 1'b1, 1'b0, 16'h0099, 8'h00);
    idle_cycles(2);

    // Write and read request together: write only
    cycle(1'b0, 1'b1, 1'b1, 16'h00A5, 8'h5A);
    idle_cycles(3);

    // Reset during ADDR_LO, then a write that must resend the address
    cycle(1'b1, 1'b1, 1'b0, 16'h3C3C, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    do_reset(1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0066, 8'h00);
    idle_cycles(4);

    // Randomised traffic, including strobes while busy
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [15:0] bv;
      r  = $urandom_range(0, 9);
      bv = ($urandom_range(0, 3) == 0) ? last_bus : 16'($urandom);
      last_bus = bv;
      case (r)
        0, 1: cycle(1'b1, 1'b0, 1'b0, bv, 8'h00);
        2:    cycle(1'b1, 1'b1, 1'b0, bv, 8'h00);
        3, 4: cycle(1'b0, 1'b1, 1'b0, bv, 8'h00);
        5, 6: cycle(1'b0, 1'b0, 1'b1, bv, 8'($urandom));
        7:    cycle(1'b0, 1'b1, 1'b1, bv, 8'($urandom));
        default: cycle(1'b0, 1'b0, 1'b0, bv, 8'h00);
      endcase
      if (i == 200) do_reset($urandom_range(1, 2));
    end
    idle_cycles(12);

    chk("beats_drained", 64'(exp_q.size()), 64'h0);
    chk("reads_drained", 64'(rd_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sap3_ext_mem_bridge.md
Name: sap3_ext_mem_bridge

Overview:
- Sits between the SAP-3 core's memory strobes and the chip pads. It turns core address, write and read requests into a byte-wide external bus protocol on the bidirectional pads.
- Each access is sequenced as: address-high phase, address-low phase, then a write phase or a wait-state read phase.
- It skips the address phases when the external latch already holds the current address, and stalls the core via core_busy while an access is in flight.

Parameters:
- RD_WAIT, 1, extra read-strobe cycles before sampling pad_in; legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- core_bus  input  16  core bus value. Address source on core_mar_we; [7:0] is write data on core_ram_we.
- core_mar_we  input  1  latch core_bus as the access address.
- core_ram_we  input  1  write core_bus[7:0] to the latched address.
- core_rd_req  input  1  read from the latched address.
- core_busy  output  1  access in flight; strobes are ignored while high.
- core_rd_data  output  8  last read byte; held until the next read completes.
- core_rd_valid  output  1  one-cycle pulse when core_rd_data is updated.
- pad_in  input  8  external read data (ui_in).
- pad_out  output  8  byte driven onto the external bus (uio_out).
- pad_oe  output  8  pad output enables, 8'hFF or 8'h00 (uio_oe).
- pad_ale_hi  output  1  external latch strobe for address[15:8].
- pad_ale_lo  output  1  external latch strobe for address[7:0].
- pad_we  output  1  external write strobe.
- pad_re  output  1  external read strobe.

Behaviour:
- All outputs are registered (Moore). Registered state: addr[15:0], wdata[7:0], op (WR/RD), addr_dirty, wait counter[3:0].
- Reset (rst_n low at a clk edge) forces:
  - state IDLE;
  - pad_out=00, pad_oe=00, all strobes 0;
  - core_busy=0, core_rd_data=00, core_rd_valid=0;
  - addr=0000, addr_dirty=1.
  - Reset mid-access aborts it at that same edge with no partial strobe afterwards. The next access always resends the address.
- IDLE: pad_oe=00, pad_out=00, strobes 0, core_busy=0.
  - core_mar_we: addr<=core_bus, addr_dirty<=1. No pad activity.
  - core_ram_we: wdata<=core_bus[7:0], op<=WR.
  - core_rd_req: op<=RD.
  - Accept on ram_we or rd_req: next state is ADDR_HI if addr_dirty (or if mar_we is high the same cycle), else WR/RD. core_busy=1 from the next cycle.
  - mar_we and ram_we in the same cycle: address is core_bus and data is core_bus[7:0]; address phases run.
  - ram_we and rd_req in the same cycle: write wins and rd_req is dropped.
- ADDR_HI (1 cycle): pad_out=addr[15:8], pad_oe=FF, pad_ale_hi=1.
- ADDR_LO (1 cycle): pad_out=addr[7:0], pad_oe=FF, pad_ale_lo=1. addr_dirty<=0 on exit. Goes to WR or RD by op.
- WR (1 cycle): pad_out=wdata, pad_oe=FF, pad_we=1. Then IDLE.
- RD (RD_WAIT+1 cycles): pad_oe=00, pad_out=00, pad_re=1. The counter loads RD_WAIT on entry and decrements each cycle.
  - At the edge ending the cycle where the counter is 0: core_rd_data<=pad_in, core_rd_valid<=1, state<=IDLE.
  - core_rd_valid clears the following cycle.
- The bus is never driven in the same cycle as pad_re. Every RD→IDLE and WR→IDLE transition passes through IDLE with pad_oe=00, so there is no turnaround overlap.
- While core_busy=1, all core strobes are ignored, including mar_we; addr is unchanged.
- core_busy deasserts in the IDLE cycle. A new request accepted in that cycle starts on the next edge.
- Latency from the accept edge to back-in-IDLE:
  - write: 3 cycles with a dirty address, 1 cycle clean;
  - read: 2+RD_WAIT+1 cycles dirty, RD_WAIT+1 clean.
- addr_dirty is set by every accepted mar_we, even if the value is unchanged. It is cleared only by completing ADDR_LO.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random core strobes → all outputs at reset values, core_busy=0, no strobes.
- Dirty write: mar_we with core_bus=12AB, then ram_we with core_bus=0055 → three consecutive cycles: (pad_out=12, ale_hi), (AB, ale_lo), (55, we). pad_oe=FF in all three, core_busy=1 in all three, then IDLE with pad_oe=00.
- Clean write: a second ram_we with core_bus=0077 and no mar_we → a single WR cycle with pad_out=77, pad_we=1; no ale strobes.
- Read with RD_WAIT=2: rd_req at a clean address, pad_in=C3 → pad_re=1 and pad_oe=00 for 3 cycles. Then core_rd_data=C3 with a 1-cycle core_rd_valid pulse; core_rd_data holds C3 afterwards.
- Contention: during a busy write, pulse mar_we with core_bus=BEEF → ignored (the next access skips ADDR phases). Simultaneous ram_we and rd_req in IDLE → write only, no pad_re, no core_rd_valid.
- Reset mid-op: rst_n=0 during ADDR_LO → next cycle all strobes 0, pad_oe=00. The following write resends both ADDR phases.
